int2flt_seq: RTL and testbench

//  Parametrised, handshaked integer-to-float converter. Successor of the fixed 16-bit int2flt program flow.

---
 rtl/int2flt_pkg.sv | 26 ++
 rtl/flt_rne_round.sv | 49 ++++
 rtl/int2flt_seq.sv | 134 +++++++++++++
 tb/tb_int2flt_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int2flt_pkg.sv
// Shared types and helpers for the sequential integer-to-float converter.
package int2flt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Zero bits appended below the fraction so guard and sticky always exist,
  // even when the magnitude is narrower than the stored mantissa.
  localparam int RNE_PAD = 2;

  // Total packed float width: sign + exponent + stored mantissa.
  function automatic int flt_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Largest finite biased exponent; anything above becomes infinity.
  function automatic int exp_max(input int exp_w);
    return (2 ** exp_w) - 2;
  endfunction

endpackage

// File: rtl/flt_rne_round.sv
// Combinational round-to-nearest-even of a normalised magnitude, including
// mantissa carry into the exponent and exponent overflow to infinity.
module flt_rne_round
  import int2flt_pkg::*;
#(
  parameter int M     = 15,
  parameter int XW    = 7,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                         sign,
  input  logic [M-2:0]                 frac_in,
  input  logic [XW-1:0]                exp_in,
  output logic [flt_w(EXP_W,MAN_W)-1:0] data,
  output logic                         ovf,
  output logic                         inexact
);

  localparam int FRW = M - 1 + MAN_W + RNE_PAD;
  localparam int EMX = exp_max(EXP_W);

  logic [FRW-1:0]   frac;
  logic [MAN_W-1:0] mant;
  logic             guard;
  logic             sticky;
  logic             up;
  logic [MAN_W:0]   sum;
  logic [XW-1:0]    exp_r;

  // Extract mantissa/guard/sticky, apply RNE, and saturate to infinity.
  always_comb begin
    frac    = {frac_in, {(MAN_W + RNE_PAD){1'b0}}};
    mant    = frac[FRW-1 -: MAN_W];
    guard   = frac[FRW-1-MAN_W];
    sticky  = |frac[FRW-2-MAN_W:0];
    up      = guard & (mant[0] | sticky);
    sum     = {1'b0, mant} + {{MAN_W{1'b0}}, up};
    exp_r   = exp_in + {{(XW-1){1'b0}}, sum[MAN_W]};
    inexact = guard | sticky;
    ovf     = (exp_r > XW'(EMX));
    if (ovf) begin
      data = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      // On carry the low bits of sum are already zero.
      data = {sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/int2flt_seq.sv
// Handshaked integer-to-float converter: serial normalisation (1 bit/cycle)
// followed by a registered RNE rounding step.
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter int INT_W     = 16,
  parameter int EXP_W     = 5,
  parameter int MAN_W     = 10,
  parameter int BIAS      = 15,
  parameter int TWOS_COMP = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_W-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [flt_w(EXP_W,MAN_W)-1:0] out_data,
  output logic                          out_ovf,
  output logic                          out_inexact,
  output logic                          busy
);

  localparam int FW  = flt_w(EXP_W, MAN_W);
  localparam int M   = (TWOS_COMP != 0) ? INT_W : INT_W - 1;
  localparam int EB  = $clog2(BIAS + INT_W + 2);
  localparam int XW  = ((EB > EXP_W) ? EB : EXP_W) + 1;

  state_t           state;
  logic [INT_W-1:0] op;
  logic [M-1:0]     mag;
  logic [XW-1:0]    exp_q;
  logic             sign;
  logic [M-1:0]     load_mag;
  logic [FW-1:0]    rnd_data;
  logic             rnd_ovf;
  logic             rnd_inx;

  // Magnitude of the latched operand; two's-complement negation is done at
  // full INT_W width so the most-negative value stays exact.
  always_comb begin
    if (TWOS_COMP != 0) begin
      load_mag = M'(op[INT_W-1] ? -op : op);
    end else begin
      load_mag = M'(op);
    end
  end

  flt_rne_round #(
    .M     (M),
    .XW    (XW),
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign    (sign),
    .frac_in (mag[M-2:0]),
    .exp_in  (exp_q),
    .data    (rnd_data),
    .ovf     (rnd_ovf),
    .inexact (rnd_inx)
  );

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
      busy        <= 1'b0;
      op          <= '0;
      mag         <= '0;
      exp_q       <= '0;
      sign        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op       <= in_data;
            state    <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          sign  <= op[INT_W-1];
          mag   <= load_mag;
          exp_q <= XW'(BIAS + M - 1);
          if (load_mag == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_data    <= {op[INT_W-1], {(FW-1){1'b0}}};
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (mag[M-1]) begin
            state <= ROUND;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - XW'(1);
          end
        end
        ROUND: begin
          out_data    <= rnd_data;
          out_ovf     <= rnd_ovf;
          out_inexact <= rnd_inx;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2flt_seq.sv
// Directed and random checks of int2flt_seq in three configurations:
// sign-magnitude default, two's complement, and a narrow 4-bit exponent.
module tb_int2flt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv0, iv1, iv2;
  logic [15:0] id0, id1, id2;
  logic        or0, or1, or2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [15:0] od0, od1;
  logic [14:0] od2;
  logic        ovf0, ovf1, ovf2;
  logic        inx0, inx1, inx2;
  logic        bsy0, bsy1, bsy2;

  int npass  = 0;
  int ntotal = 0;

  int2flt_seq u_sm (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ovf(ovf0),
    .out_inexact(inx0), .busy(bsy0)
  );

  int2flt_seq #(.TWOS_COMP(1)) u_tc (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ovf(ovf1),
    .out_inexact(inx1), .busy(bsy1)
  );

  int2flt_seq #(.EXP_W(4), .BIAS(7), .MAN_W(10)) u_ov (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ovf(ovf2),
    .out_inexact(inx2), .busy(bsy2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic f_ir(input int m);
    case (m) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction
  function automatic logic f_ov(input int m);
    case (m) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [15:0] f_od(input int m);
    case (m) 0: return od0; 1: return od1; default: return {1'b0, od2}; endcase
  endfunction
  function automatic logic f_ovf(input int m);
    case (m) 0: return ovf0; 1: return ovf1; default: return ovf2; endcase
  endfunction
  function automatic logic f_inx(input int m);
    case (m) 0: return inx0; 1: return inx1; default: return inx2; endcase
  endfunction
  function automatic logic f_busy(input int m);
    case (m) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
  endfunction

  task automatic set_in(input int m, input logic v, input logic [15:0] d);
    case (m)
      0: begin iv0 = v; id0 = d; end
      1: begin iv1 = v; id1 = d; end
      default: begin iv2 = v; id2 = d; end
    endcase
  endtask

  task automatic set_or(input int m, input logic v);
    case (m)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  // Offer one operand, wait for the result; lat = clock edges after accept.
  task automatic run(input int m, input logic [15:0] d, output logic [15:0] res,
                     output logic ovf, output logic inx, output int lat);
    int w = 0;
    while (!f_ir(m) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) begin
      ntotal++;
      $error("FAIL ready_timeout: observed in_ready=0 expected 1");
    end
    set_in(m, 1'b1, d);
    @(posedge clk); #1;
    set_in(m, 1'b0, 16'h0000);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!f_ov(m) && lat < 100);
    if (!f_ov(m)) begin
      ntotal++;
      $error("FAIL valid_timeout: observed out_valid=0 expected 1");
    end
    res = f_od(m);
    ovf = f_ovf(m);
    inx = f_inx(m);
  endtask

  task automatic take(input int m);
    set_or(m, 1'b1);
    @(posedge clk); #1;
    set_or(m, 1'b0);
  endtask

  // Reference conversion by explicit bit-position search and remainder compare.
  function automatic logic [17:0] model(input logic [15:0] d, input int twos,
                                        input int ew, input int mw, input int bias);
    longint mag, full, rem, half, mant, res;
    int p, e, sh;
    logic s, ovf, inx;
    s = d[15]; ovf = 1'b0; inx = 1'b0;
    if (twos != 0) mag = s ? (longint'(65536) - longint'(d)) : longint'(d);
    else mag = longint'(d[14:0]);
    if (mag == 0) begin
      res = longint'(s) << (ew + mw);
      return {2'b00, res[15:0]};
    end
    p = 0;
    for (int i = 0; i < 17; i++) if (mag[i]) p = i;
    e = bias + p;
    if (p > mw) begin
      sh   = p - mw;
      full = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && full[0])) full++;
      if ((full >> (mw + 1)) != 0) begin
        full = full >> 1;
        e++;
      end
      mant = full & ((longint'(1) << mw) - 1);
    end else begin
      mant = (mag << (mw - p)) & ((longint'(1) << mw) - 1);
    end
    if (e > (1 << ew) - 2) begin
      ovf  = 1'b1;
      e    = (1 << ew) - 1;
      mant = 0;
    end
    res = (longint'(s) << (ew + mw)) | (longint'(e) << mw) | mant;
    return {ovf, inx, res[15:0]};
  endfunction

  initial begin
    logic [15:0] res, d;
    logic        ovf, inx;
    logic [17:0] exp_m;
    int          lat;

    reset = 1'b0;
    iv0 = 0; iv1 = 0; iv2 = 0;
    id0 = '0; id1 = '0; id2 = '0;
    or0 = 0; or1 = 0; or2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", f_ir(0), 1);
    check("rst_out_valid", f_ov(0), 0);
    check("rst_out_data", f_od(0), 16'h0000);
    check("rst_ovf", f_ovf(0), 0);
    check("rst_inexact", f_inx(0), 0);
    check("rst_busy", f_busy(0), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Sign-magnitude directed vectors.
    run(0, 16'h0001, res, ovf, inx, lat);
    check("one_data", res, 16'h3C00);
    check("one_inexact", inx, 0);
    check("one_latency", lat, 17);
    take(0);
    run(0, 16'h0003, res, ovf, inx, lat);
    check("three_data", res, 16'h4200);
    check("three_latency", lat, 16);
    take(0);
    run(0, 16'h000C, res, ovf, inx, lat);
    check("twelve_data", res, 16'h4A00);
    take(0);
    run(0, 16'h0000, res, ovf, inx, lat);
    check("zero_data", res, 16'h0000);
    check("zero_latency_le2", (lat <= 2), 1);
    take(0);
    run(0, 16'h8000, res, ovf, inx, lat);
    check("negzero_data", res, 16'h8000);
    take(0);
    run(0, 16'h7FFF, res, ovf, inx, lat);
    check("max_carry_data", res, 16'h7800);
    check("max_carry_inexact", inx, 1);
    check("max_carry_ovf", ovf, 0);
    take(0);
    run(0, 16'h4008, res, ovf, inx, lat);
    check("tie_even_data", res, 16'h7400);
    check("tie_even_inexact", inx, 1);
    take(0);
    // Tie with an odd mantissa lsb (mantissa 1) rounds up to the even value 2.
    run(0, 16'h4018, res, ovf, inx, lat);
    check("tie_odd_data", res, 16'h7402);
    take(0);

    // Two's-complement directed vectors.
    run(1, 16'hFFFF, res, ovf, inx, lat);
    check("tc_m1_data", res, 16'hBC00);
    take(1);
    run(1, 16'h8000, res, ovf, inx, lat);
    check("tc_min_data", res, 16'hF800);
    check("tc_min_inexact", inx, 0);
    take(1);
    run(1, 16'h7FFF, res, ovf, inx, lat);
    check("tc_max_data", res, 16'h7800);
    take(1);

    // Narrow exponent overflows to +inf.
    run(2, 16'h4000, res, ovf, inx, lat);
    check("ovf_flag", ovf, 1);
    check("ovf_data", res, 16'h3C00);
    take(2);

    // Backpressure: result must hold while out_ready stays low.
    run(0, 16'h0003, res, ovf, inx, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", f_ov(0), 1);
      check("hold_data", f_od(0), 16'h4200);
      check("hold_in_ready", f_ir(0), 0);
    end
    take(0);
    check("after_take_ready", f_ir(0), 1);

    // Reset while normalising discards the operand.
    set_in(0, 1'b1, 16'h0001);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", f_busy(0), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_ready", f_ir(0), 1);
    check("mid_rst_valid", f_ov(0), 0);
    check("mid_rst_busy", f_busy(0), 0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_output", f_ov(0), 0);

    // Random operands per configuration against the reference model.
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 20; k++) begin
        d = 16'($urandom);
        run(m, d, res, ovf, inx, lat);
        case (m)
          0: exp_m = model(d, 0, 5, 10, 15);
          1: exp_m = model(d, 1, 5, 10, 15);
          default: exp_m = model(d, 0, 4, 10, 7);
        endcase
        check("rand_data", res, exp_m[15:0]);
        check("rand_ovf", ovf, exp_m[17]);
        check("rand_inexact", inx, exp_m[16]);
        take(m);
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
